// File: rtl/rvvi_trace_pkg.sv
// Shared retire-record type, privilege-mode constants and ORDER distance helper
// for the RVVI retire buffer. Record fields are sized for XLEN up to 64.
package rvvi_trace_pkg;

   localparam int unsigned RB_XLEN = 64;

   localparam logic [1:0] MODE_U = 2'd0;
   localparam logic [1:0] MODE_S = 2'd1;
   localparam logic [1:0] MODE_M = 2'd3;

   typedef struct packed {
      logic [31:0]        insn;
      logic [RB_XLEN-1:0] pc;
      logic               trap;
      logic [1:0]         mode;
      logic               x_wb;
      logic [4:0]         x_idx;
      logic [RB_XLEN-1:0] x_wdata;
      logic               csr_wb;
      logic [11:0]        csr_addr;
      logic [RB_XLEN-1:0] csr_data;
   } retire_rec_t;

   // Distance of order ahead of head, modulo 2^width (width <= 32).
   function automatic logic [31:0] order_diff(input logic [31:0] order,
                                              input logic [31:0] head,
                                              input int unsigned width);
      logic [31:0] d;
      d = order - head;
      if (width < 32) d = d & ((32'd1 << width) - 32'd1);
      return d;
   endfunction

endpackage

// File: rtl/rvvi_rb_slots.sv
// Reorder-window storage: DEPTH retire records plus per-slot valid bits,
// one write port and one combined read/clear port.
module rvvi_rb_slots
   import rvvi_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  retire_rec_t      wr_rec_i,
   output logic             wr_occ_o,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic             clr_i,
   output retire_rec_t      rd_rec_o,
   output logic             rd_valid_o
);

   logic [DEPTH-1:0] valid_q, valid_d;
   retire_rec_t      mem_q [DEPTH];

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      valid_d = valid_q;
      if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
      if (clr_i)   valid_d[rd_idx_i] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   // NOTE: record storage has no reset; the valid bits alone decide whether a slot is live.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_rec_i;
   end

   assign wr_occ_o   = valid_q[wr_idx_i];
   assign rd_rec_o   = mem_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/rvvi_retire_buffer.sv
// Reorders ORDER-tagged retire records into a strictly sequential stream for RVVI.
// Optional stall watchdog (WD_CYCLES, wd_err) is enabled by RVVI_RB_WATCHDOG_EN.
module rvvi_retire_buffer
   import rvvi_trace_pkg::*;
#(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ORDER_W    = 16,
   parameter int unsigned ORDER_BASE = 0
`ifdef RVVI_RB_WATCHDOG_EN
   , parameter int unsigned WD_CYCLES = 1024
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ORDER_W-1:0]       in_order,
   input  logic [31:0]              in_insn,
   input  logic [XLEN-1:0]          in_pc,
   input  logic                     in_trap,
   input  logic [1:0]               in_mode,
   input  logic                     in_x_wb,
   input  logic [4:0]               in_x_idx,
   input  logic [XLEN-1:0]          in_x_wdata,
   input  logic                     in_csr_wb,
   input  logic [11:0]              in_csr_addr,
   input  logic [XLEN-1:0]          in_csr_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ORDER_W-1:0]       out_order,
   output logic [31:0]              out_insn,
   output logic [XLEN-1:0]          out_pc,
   output logic                     out_trap,
   output logic [1:0]               out_mode,
   output logic                     out_x_wb,
   output logic [4:0]               out_x_idx,
   output logic [XLEN-1:0]          out_x_wdata,
   output logic                     out_csr_wb,
   output logic [11:0]              out_csr_addr,
   output logic [XLEN-1:0]          out_csr_data,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     dup_err,
   output logic                     stale_err
`ifdef RVVI_RB_WATCHDOG_EN
   , output logic                   wd_err
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [ORDER_W-1:0] head_q, head_d, diff, out_order_q, out_order_d;
   logic               in_window, is_stale, accept, drain_free, bypass, wr_en, clr;
   logic               slot_occ, head_valid;
   logic               out_valid_q, out_valid_d, dup_q, dup_d, stale_q, stale_d;
   logic [IDX_W:0]     occ_q, occ_d;
   retire_rec_t        in_rec, slot_rec, out_rec_q, out_rec_d;

   always_comb begin
      in_rec          = '0;
      in_rec.insn     = in_insn;
      in_rec.pc       = RB_XLEN'(in_pc);
      in_rec.trap     = in_trap;
      in_rec.mode     = in_mode;
      in_rec.x_wb     = in_x_wb;
      in_rec.x_idx    = in_x_idx;
      in_rec.x_wdata  = RB_XLEN'(in_x_wdata);
      in_rec.csr_wb   = in_csr_wb;
      in_rec.csr_addr = in_csr_addr;
      in_rec.csr_data = RB_XLEN'(in_csr_data);
   end

   // Upper half of the ORDER space behind head is stale; the rest beyond the window stalls.
   assign diff       = ORDER_W'(order_diff(32'(in_order), 32'(head_q), ORDER_W));
   assign in_window  = diff < ORDER_W'(DEPTH);
   assign is_stale   = diff[ORDER_W-1];
   assign in_ready   = in_window | is_stale;
   assign accept     = in_valid & in_ready;
   assign drain_free = ~out_valid_q | out_ready;
   assign bypass     = drain_free & ~head_valid & accept & (diff == '0);
   assign wr_en      = accept & in_window & ~slot_occ & ~bypass;
   assign clr        = drain_free & head_valid;

   rvvi_rb_slots #(.DEPTH(DEPTH)) u_slots (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en),
      .wr_idx_i   (in_order[IDX_W-1:0]),
      .wr_rec_i   (in_rec),
      .wr_occ_o   (slot_occ),
      .rd_idx_i   (head_q[IDX_W-1:0]),
      .clr_i      (clr),
      .rd_rec_o   (slot_rec),
      .rd_valid_o (head_valid)
   );

   always_comb begin
      head_d      = head_q;
      out_valid_d = out_valid_q;
      out_order_d = out_order_q;
      out_rec_d   = out_rec_q;
      if (drain_free) begin
         if (head_valid) begin
            out_valid_d = 1'b1;
            out_order_d = head_q;
            out_rec_d   = slot_rec;
            head_d      = head_q + ORDER_W'(1);
         end else if (bypass) begin
            out_valid_d = 1'b1;
            out_order_d = in_order;
            out_rec_d   = in_rec;
            head_d      = head_q + ORDER_W'(1);
         end else begin
            out_valid_d = 1'b0;
         end
      end
      occ_d   = occ_q + (IDX_W+1)'(wr_en) - (IDX_W+1)'(clr);
      dup_d   = dup_q | (accept & in_window & slot_occ);
      stale_d = stale_q | (accept & is_stale);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q      <= ORDER_W'(ORDER_BASE);
         out_valid_q <= 1'b0;
         out_order_q <= '0;
         out_rec_q   <= '0;
         occ_q       <= '0;
         dup_q       <= 1'b0;
         stale_q     <= 1'b0;
      end else begin
         head_q      <= head_d;
         out_valid_q <= out_valid_d;
         out_order_q <= out_order_d;
         out_rec_q   <= out_rec_d;
         occ_q       <= occ_d;
         dup_q       <= dup_d;
         stale_q     <= stale_d;
      end
   end

`ifdef RVVI_RB_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            wd_err_q, wd_err_d;

   // Counts cycles the buffer holds records but cannot make progress at head.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (clr | bypass)
         wd_cnt_d = '0;
      else if ((occ_q != '0) && !head_valid && (wd_cnt_q != WD_W'(WD_CYCLES)))
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      wd_err_d = wd_err_q | (wd_cnt_d == WD_W'(WD_CYCLES));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt_q <= '0;
         wd_err_q <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wd_err_q <= wd_err_d;
      end
   end

   assign wd_err = wd_err_q;
`endif

   assign out_valid    = out_valid_q;
   assign out_order    = out_order_q;
   assign out_insn     = out_rec_q.insn;
   assign out_pc       = out_rec_q.pc[XLEN-1:0];
   assign out_trap     = out_rec_q.trap;
   assign out_mode     = out_rec_q.mode;
   assign out_x_wb     = out_rec_q.x_wb;
   assign out_x_idx    = out_rec_q.x_idx;
   assign out_x_wdata  = out_rec_q.x_wdata[XLEN-1:0];
   assign out_csr_wb   = out_rec_q.csr_wb;
   assign out_csr_addr = out_rec_q.csr_addr;
   assign out_csr_data = out_rec_q.csr_data[XLEN-1:0];
   assign occupancy    = occ_q;
   assign dup_err      = dup_q;
   assign stale_err    = stale_q;

endmodule
